// File: rtl/axi_async_fifo.sv
// Dual-clock FWFT FIFO for AXI channel crossings: Gray pointers, multi-flop pointer sync,
// per-side levels, almost flags and overflow/underflow pulses.
`timescale 1ns/1ps
module axi_async_fifo #(
  parameter int WIDTH       = 37,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = 3,
  parameter int AEMPTY_TH   = 1
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic                     rclk,
  input  logic                     rrst,
  input  logic                     winc,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     wfull,
  output logic                     walmost_full,
  output logic [$clog2(DEPTH):0]   wlevel,
  output logic                     woverflow,
  input  logic                     rinc,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rempty,
  output logic                     ralmost_empty,
  output logic [$clog2(DEPTH):0]   rlevel,
  output logic                     runderflow
);
  localparam int AW = $clog2(DEPTH);
  // Full when the write Gray pointer equals the read Gray pointer with its top two bits flipped.
  localparam logic [AW:0] FULL_MASK = (AW+1)'(3 << (AW-1));

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW:0] wbin_q, wbin_d, wgray_q, wgray_d;
  logic [AW:0] rbin_q, rbin_d, rgray_q, rgray_d;
  logic [AW:0] rsync_q [SYNC_STAGES];
  logic [AW:0] wsync_q [SYNC_STAGES];
  logic        wfull_q, wfull_d, woverflow_q;
  logic        rempty_q, rempty_d, runderflow_q;
  logic        wpush, rpop;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Flags compare against the value entering the last sync stage, so the registered flag
  // always matches the pointers visible after the same edge.
  always_comb begin
    wpush   = winc & ~wfull_q;
    wbin_d  = wbin_q + {{AW{1'b0}}, wpush};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    wfull_d = (wgray_d == (rsync_q[SYNC_STAGES-2] ^ FULL_MASK));
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q      <= '0;
      wgray_q     <= '0;
      wfull_q     <= 1'b0;
      woverflow_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) rsync_q[i] <= '0;
    end else begin
      wbin_q      <= wbin_d;
      wgray_q     <= wgray_d;
      wfull_q     <= wfull_d;
      woverflow_q <= winc & wfull_q;
      rsync_q[0]  <= rgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) rsync_q[i] <= rsync_q[i-1];
    end
  end

  always_ff @(posedge wclk) begin
    if (wpush) mem_q[wbin_q[AW-1:0]] <= wdata;
  end

  always_comb begin
    rpop     = rinc & ~rempty_q;
    rbin_d   = rbin_q + {{AW{1'b0}}, rpop};
    rgray_d  = rbin_d ^ (rbin_d >> 1);
    rempty_d = (rgray_d == wsync_q[SYNC_STAGES-2]);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q       <= '0;
      rgray_q      <= '0;
      rempty_q     <= 1'b1;
      runderflow_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) wsync_q[i] <= '0;
    end else begin
      rbin_q       <= rbin_d;
      rgray_q      <= rgray_d;
      rempty_q     <= rempty_d;
      runderflow_q <= rinc & rempty_q;
      wsync_q[0]   <= wgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) wsync_q[i] <= wsync_q[i-1];
    end
  end

  assign wfull         = wfull_q;
  assign woverflow     = woverflow_q;
  assign wlevel        = wbin_q - gray2bin(rsync_q[SYNC_STAGES-1]);
  assign walmost_full  = (wlevel >= (AW+1)'(AFULL_TH));
  assign rempty        = rempty_q;
  assign runderflow    = runderflow_q;
  assign rlevel        = gray2bin(wsync_q[SYNC_STAGES-1]) - rbin_q;
  assign ralmost_empty = (rlevel <= (AW+1)'(AEMPTY_TH));
  assign rdata         = rempty_q ? '0 : mem_q[rbin_q[AW-1:0]];

`ifndef SYNTHESIS
  // Resetting only one domain would desynchronise the pointer pair.
  always @(posedge wclk) begin
    a_joint_reset: assert (wrst == rrst);
  end
`endif
endmodule

// File: tb/tb_axi_async_fifo.sv
// Randomised dual-clock bench for axi_async_fifo with a queue-based reference model.
`timescale 1ns/1ps
module tb_axi_async_fifo;
  localparam int WIDTH = 37;
  localparam int DEPTH = 4;

  logic             wclk, rclk, wrst, rrst, winc, rinc;
  logic [WIDTH-1:0] wdata, rdata;
  logic             wfull, walmost_full, woverflow;
  logic             rempty, ralmost_empty, runderflow;
  logic [2:0]       wlevel, rlevel;

  int checks = 0;
  int errors = 0;
  int whalf  = 5;
  int rhalf  = 7;
  logic [WIDTH-1:0] sb_q [$];

  axi_async_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2), .AFULL_TH(3), .AEMPTY_TH(1)) dut (
    .wclk(wclk), .wrst(wrst), .rclk(rclk), .rrst(rrst),
    .winc(winc), .wdata(wdata), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .woverflow(woverflow),
    .rinc(rinc), .rdata(rdata), .rempty(rempty), .ralmost_empty(ralmost_empty),
    .rlevel(rlevel), .runderflow(runderflow)
  );

  initial begin wclk = 0; forever #(whalf) wclk = ~wclk; end
  initial begin rclk = 0; forever #(rhalf) rclk = ~rclk; end

  initial begin
    #50_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [WIDTH-1:0] d);
    @(negedge wclk); winc = 1'b1; wdata = d;
    @(negedge wclk); winc = 1'b0;
  endtask

  task automatic wait_rlevel(input int target);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge rclk);
      if (rlevel == 3'(target)) ok = 1;
    end
    check("wait_rlevel", ok, 1);
  endtask

  task automatic run_ratio(input int wh, input int rh, input int n);
    int   sent = 0, got = 0;
    logic exp_ov = 0, exp_uf = 0;
    whalf = wh; rhalf = rh;
    sb_q.delete();
    fork
      begin
        int wcyc = 0;
        logic [63:0] r64;
        while (sent < n && wcyc < n * 20) begin
          @(negedge wclk); wcyc++;
          check("woverflow", woverflow, exp_ov);
          check("wlevel_le_depth", wlevel <= 3'(DEPTH), 1);
          check("wlevel_ge_model", int'(wlevel) >= sb_q.size(), 1);
          check("wfull_vs_level", wfull, wlevel == 3'(DEPTH));
          check("walmost_full", walmost_full, wlevel >= 3'd3);
          r64 = {$urandom, $urandom};
          winc = ($urandom_range(0, 9) < 6);
          wdata = r64[WIDTH-1:0];
          exp_ov = winc & wfull;
          if (winc && !wfull) begin sb_q.push_back(wdata); sent++; end
        end
        @(negedge wclk);
        check("woverflow", woverflow, exp_ov);
        winc = 1'b0;
        check("writes_done", sent, n);
      end
      begin
        int rcyc = 0;
        while (got < n && rcyc < n * 40) begin
          @(negedge rclk); rcyc++;
          check("runderflow", runderflow, exp_uf);
          check("rlevel_le_depth", rlevel <= 3'(DEPTH), 1);
          check("rlevel_le_model", int'(rlevel) <= sb_q.size(), 1);
          check("rempty_vs_level", rempty, rlevel == 3'd0);
          check("ralmost_empty", ralmost_empty, rlevel <= 3'd1);
          if (!rempty) begin
            if (sb_q.size() == 0) check("rdata_unexpected", 1, 0);
            else check("rdata_order", rdata, sb_q[0]);
          end else begin
            check("rdata_empty", rdata, 0);
          end
          rinc = ($urandom_range(0, 9) < 6);
          exp_uf = rinc & rempty;
          if (rinc && !rempty && sb_q.size() > 0) begin
            void'(sb_q.pop_front());
            got++;
          end
        end
        @(negedge rclk);
        check("runderflow", runderflow, exp_uf);
        rinc = 1'b0;
        check("reads_done", got, n);
      end
    join
    check("scoreboard_drained", sb_q.size(), 0);
    $display("ratio whalf=%0d rhalf=%0d: %0d words transferred", wh, rh, got);
  endtask

  initial begin
    int n;
    wrst = 1; rrst = 1; winc = 0; rinc = 0; wdata = '0;
    repeat (4) @(negedge rclk);
    #0.5; wrst = 0; rrst = 0;

    // Reset state
    @(negedge wclk);
    check("rst_wfull", wfull, 0);
    check("rst_wlevel", wlevel, 0);
    check("rst_walmost_full", walmost_full, 0);
    @(negedge rclk);
    check("rst_rempty", rempty, 1);
    check("rst_rdata", rdata, 0);
    check("rst_rlevel", rlevel, 0);
    check("rst_ralmost_empty", ralmost_empty, 1);

    // Fill to full, then overflow
    wr(37'hA); wr(37'hB);
    check("fill2_wlevel", wlevel, 2);
    check("fill2_walmost_full", walmost_full, 0);
    wr(37'hC);
    check("fill3_walmost_full", walmost_full, 1);
    check("fill3_wfull", wfull, 0);
    wr(37'hD);
    check("fill4_wfull", wfull, 1);
    check("fill4_wlevel", wlevel, 4);
    wr(37'hE);
    check("overflow_pulse", woverflow, 1);
    @(negedge wclk);
    check("overflow_clear", woverflow, 0);
    check("overflow_wlevel", wlevel, 4);
    $display("fill: wlevel=%0d wfull=%0d", wlevel, wfull);

    // Drain in order, then underflow
    wait_rlevel(4);
    check("drain_ralmost_empty0", ralmost_empty, 0);
    for (int i = 0; i < 4; i++) begin
      check("drain_rdata", rdata, 37'hA + 37'(i));
      check("drain_ralmost_empty", ralmost_empty, i >= 3);
      rinc = 1'b1;
      @(negedge rclk);
    end
    rinc = 1'b0;
    check("drain_rempty", rempty, 1);
    check("drain_rdata_zero", rdata, 0);
    check("drain_rlevel", rlevel, 0);
    rinc = 1'b1;
    @(negedge rclk); rinc = 1'b0;
    check("underflow_pulse", runderflow, 1);
    @(negedge rclk);
    check("underflow_clear", runderflow, 0);
    check("underflow_rempty", rempty, 1);
    repeat (6) @(negedge wclk);
    check("drain_wlevel", wlevel, 0);
    check("drain_wfull", wfull, 0);
    $display("drain: rempty=%0d rlevel=%0d", rempty, rlevel);

    // Write-to-visible latency
    @(negedge wclk); winc = 1'b1; wdata = 37'h55;
    @(posedge wclk); #1 winc = 1'b0;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(posedge rclk); #1;
      if (!rempty) n = i;
    end
    check("latency_min", n >= 2, 1);
    check("latency_max", n <= 3 && n != 0, 1);
    $display("latency: rempty fell after %0d rclk edges", n);
    @(negedge rclk);
    check("latency_rdata", rdata, 37'h55);
    rinc = 1'b1; @(negedge rclk); rinc = 1'b0;
    check("latency_rempty", rempty, 1);

    // Random traffic at several clock ratios
    run_ratio(5, 15, 2000);
    run_ratio(15, 5, 2000);
    run_ratio(7, 5, 2000);

    // Joint reset with entries held
    whalf = 5; rhalf = 7;
    repeat (3) @(negedge rclk);
    wr(37'h111); wr(37'h222);
    wait_rlevel(2);
    #0.5; wrst = 1; rrst = 1;
    repeat (4) @(negedge rclk);
    #0.5; wrst = 0; rrst = 0;
    @(negedge wclk);
    check("jrst_wfull", wfull, 0);
    check("jrst_wlevel", wlevel, 0);
    check("jrst_walmost_full", walmost_full, 0);
    check("jrst_woverflow", woverflow, 0);
    @(negedge rclk);
    check("jrst_rempty", rempty, 1);
    check("jrst_rdata", rdata, 0);
    check("jrst_rlevel", rlevel, 0);
    check("jrst_ralmost_empty", ralmost_empty, 1);
    check("jrst_runderflow", runderflow, 0);
    wr(37'h333);
    wait_rlevel(1);
    check("jrst_first_word", rdata, 37'h333);
    $display("joint reset: first word after reset %0h", rdata);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
